fetch_unit: RTL

- Instruction-fetch stage of the 5-stage pipelined MIPS core, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to a variable-latency instruction memory through a req/ready handshake.
- Buffers up to 2 returned instructions and presents the head entry, split into MIPS fields plus PC+4, to IF/ID.
- Handles stall via pc_write (the same net as if_id_write) and redirect via branch/jump, discarding stale fetches.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_buf.sv | 56 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, fetch state
// encoding and the fetch buffer entry layout.
package mips_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RS_HI     = 25;
    localparam int unsigned RS_LO     = 21;
    localparam int unsigned RT_HI     = 20;
    localparam int unsigned RT_LO     = 16;
    localparam int unsigned RD_HI     = 15;
    localparam int unsigned RD_LO     = 11;
    localparam int unsigned FUNC_HI   = 5;
    localparam int unsigned FUNC_LO   = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response handshake between fetch and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions; entry 0 is always the head.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem0;
    fetch_entry_t mem1;
    logic         do_enq;
    logic         do_deq;

    assign do_deq = deq && (count != 2'd0);
    assign do_enq = enq && ((count != 2'd2) || do_deq);
    assign head   = mem0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({do_enq, do_deq})
                2'b10: begin
                    if (count == 2'd0) mem0 <= din;
                    else               mem1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word arrives: shift and refill.
                    if (count == 2'd1) begin
                        mem0 <= din;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues imem fetches, buffers
// returned words and presents the decoded head entry to IF/ID.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_write,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump,
    input  logic [31:0]  jump_target,
    fetch_unit_if.master imem,
    output logic         fetch_valid,
    output logic [5:0]   opcode,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [5:0]   func,
    output logic [15:0]  imm,
    output logic [31:0]  pc_plus4
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  drop_addr, drop_addr_next;
    logic [1:0]   count, count_next;
    logic         redirect, transfer, enq, deq;
    logic [31:0]  target;
    logic [31:0]  inst;
    fetch_entry_t din, head;

    assign redirect = jump | branch_taken;
    assign target   = jump ? jump_target : branch_target;
    assign transfer = imem.imem_req & imem.imem_ready;
    assign enq      = (state == REQ) && transfer && !redirect;
    assign deq      = pc_write && (count != 2'd0);

    assign din.inst     = imem.imem_rdata;
    assign din.pc_plus4 = pc + 32'd4;

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (pc_write),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );

    always_comb begin
        count_next = count + {1'b0, enq} - {1'b0, deq};
        if (redirect) count_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = REQ;
                end else if (count_next != 2'd2) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_next = target;
                    // An outstanding request must complete at its original address.
                    if (!transfer) begin
                        drop_addr_next = pc;
                        state_next     = DROP;
                    end
                end else if (transfer) begin
                    pc_next    = pc + 32'd4;
                    state_next = (count_next == 2'd2) ? IDLE : REQ;
                end
            end
            DROP: begin
                if (redirect)      pc_next    = target;
                else if (transfer) state_next = REQ;
            end
            default: state_next = REQ;
        endcase
    end

    assign imem.imem_req  = (state != IDLE);
    assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

    assign fetch_valid = (count != 2'd0) && !redirect;
    assign inst        = fetch_valid ? head.inst : NOP_INST;
    assign pc_plus4    = fetch_valid ? head.pc_plus4 : '0;
    assign opcode      = inst[OPCODE_HI:OPCODE_LO];
    assign rs          = inst[RS_HI:RS_LO];
    assign rt          = inst[RT_HI:RT_LO];
    assign rd          = inst[RD_HI:RD_LO];
    assign func        = inst[FUNC_HI:FUNC_LO];
    assign imm         = inst[IMM_HI:IMM_LO];

endmodule
